// File: rtl/param_memory_if.sv
// Request/response bundle for param_memory: request strobe, write payload,
// clear pulse and read results.
interface param_memory_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                    enable;
    logic                    write;
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH-1:0]   data_in;
    logic [DATA_WIDTH/8-1:0] byte_en;
    logic                    clear;
    logic                    ready;
    logic                    busy;
    logic [DATA_WIDTH-1:0]   data_out;
    logic                    data_valid;
    logic                    error;

    modport master (
        output enable, write, address, data_in, byte_en, clear,
        input  ready, busy, data_out, data_valid, error
    );

    modport slave (
        input  enable, write, address, data_in, byte_en, clear,
        output ready, busy, data_out, data_valid, error
    );
endinterface

// File: rtl/param_memory.sv
// Single-port word memory with byte-enable writes, a fixed-latency read
// pipeline and a one-word-per-cycle zero-fill triggered by a clear pulse.
module param_memory #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic           clock,
    input  logic           reset_n,
    param_memory_if.slave  bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("param_memory: READ_LATENCY must be in 1..4");
    end
    if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("param_memory: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("param_memory: DEPTH must be in 1..2**ADDR_WIDTH");
    end

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  ready;
    logic                  accept;
    logic                  in_range;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data_d;

    logic [READ_LATENCY-1:0] pipe_vld_q;
    logic [READ_LATENCY-1:0] pipe_err_q;
    logic [DATA_WIDTH-1:0]   pipe_data_q [READ_LATENCY];

    assign ready     = (state_q == IDLE) && !bus.clear;
    assign accept    = bus.enable && ready;
    assign in_range  = {1'b0, bus.address} < DEPTH_W;
    assign wr_en     = accept && bus.write && in_range;
    assign rd_en     = accept && !bus.write;
    assign rd_data_d = in_range ? mem_q[bus.address] : '0;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            IDLE: begin
                if (bus.clear) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == LAST_ADDR) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // NOTE: the array has no reset; contents survive reset_n and only the fill zeroes them.
    always_ff @(posedge clock) begin
        if (state_q == CLEAR) begin
            mem_q[clr_addr_q] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (bus.byte_en[b]) mem_q[bus.address][8*b +: 8] <= bus.data_in[8*b +: 8];
            end
        end
    end

    // Data stages load only behind a valid, so the last stage holds the previous result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_vld_q <= '0;
            pipe_err_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) pipe_data_q[i] <= '0;
        end else begin
            pipe_vld_q[0] <= rd_en;
            pipe_err_q[0] <= rd_en && !in_range;
            if (rd_en) pipe_data_q[0] <= rd_data_d;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_err_q[i] <= pipe_err_q[i-1];
                if (pipe_vld_q[i-1]) pipe_data_q[i] <= pipe_data_q[i-1];
            end
        end
    end

    assign bus.ready      = ready;
    assign bus.busy       = (state_q == CLEAR);
    assign bus.data_valid = pipe_vld_q[READ_LATENCY-1];
    assign bus.error      = pipe_err_q[READ_LATENCY-1];
    assign bus.data_out   = pipe_data_q[READ_LATENCY-1];
endmodule
